// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : Bit-serial two's-complement subtractor computing a - b, LSB
//             first, one bit per clock through a single full-subtractor cell
//             and a borrow flip-flop. Wrapped in a start/busy/done handshake;
//             results are registered and held until the next operation ends.
//  Ports    : clk    - system clock, rising edge
//             rst_n  - asynchronous active-low reset
//             start  - request pulse, accepted only in IDLE
//             a, b   - minuend / subtrahend, sampled when start is accepted
//             busy   - high while the subtraction runs (RUN state)
//             done   - one-cycle pulse, results valid (DONE state)
//             diff   - a - b modulo 2^WIDTH
//             borrow - unsigned borrow out (a < b unsigned)
//             ovf    - signed overflow of a - b
//             zero   - diff == 0
//  Revision : 1.0  initial release
// ============================================================================
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             borrow,
   output logic             ovf,
   output logic             zero
);

   localparam int c_cnt_w = $clog2(WIDTH) + 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

   typedef enum logic [1:0] {
      s_idle = 2'd0,
      s_run  = 2'd1,
      s_done = 2'd2
   } state_t;

   state_t r_state;
   state_t w_state_next;

   logic [WIDTH-1:0]   r_sa;
   logic [WIDTH-1:0]   r_sb;
   logic [WIDTH-1:0]   r_res;
   logic               r_br;
   logic               r_amsb;
   logic               r_bmsb;
   logic [c_cnt_w-1:0] r_cnt;

   logic               w_x;
   logic               w_y;
   logic               w_d;
   logic               w_br_next;
   logic               w_last;
   logic [WIDTH-1:0]   w_res_next;

   // Full-subtractor cell on the current LSBs
   assign w_x        = r_sa[0];
   assign w_y        = r_sb[0];
   assign w_d        = w_x ^ w_y ^ r_br;
   assign w_br_next  = (~w_x & w_y) | (~(w_x ^ w_y) & r_br);
   assign w_last     = (r_cnt == c_last);
   // Result bits enter from the MSB side so that after WIDTH shifts bit 0
   // of the operands ends up at bit 0 of the result.
   assign w_res_next = {w_d, r_res[WIDTH-1:1]};

   assign busy = (r_state == s_run);
   assign done = (r_state == s_done);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= s_idle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         s_idle:  if (start) w_state_next = s_run;
         s_run:   if (w_last) w_state_next = s_done;
         s_done:  w_state_next = s_idle;
         default: w_state_next = s_idle;
      endcase
   end

   // Datapath: operand shift registers, borrow flop, counter and the
   // result registers, which only change on the final bit of an operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_res  <= '0;
         r_br   <= 1'b0;
         r_amsb <= 1'b0;
         r_bmsb <= 1'b0;
         r_cnt  <= '0;
         diff   <= '0;
         borrow <= 1'b0;
         ovf    <= 1'b0;
         zero   <= 1'b0;
      end else begin
         case (r_state)
            s_idle: begin
               if (start) begin
                  r_sa   <= a;
                  r_sb   <= b;
                  r_res  <= '0;
                  r_amsb <= a[WIDTH-1];
                  r_bmsb <= b[WIDTH-1];
                  r_br   <= 1'b0;
                  r_cnt  <= '0;
               end
            end
            s_run: begin
               r_sa  <= r_sa >> 1;
               r_sb  <= r_sb >> 1;
               r_res <= w_res_next;
               r_br  <= w_br_next;
               r_cnt <= r_cnt + 1'b1;
               if (w_last) begin
                  diff   <= w_res_next;
                  borrow <= w_br_next;
                  // w_d is the result MSB on the final bit
                  ovf    <= (r_amsb != r_bmsb) && (w_d != r_amsb);
                  zero   <= (w_res_next == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire
